// File: rtl/mac_pkg.sv
// Shared definitions for the matrix multiply engine: FSM states, legal
// read-latency range and an address-width helper.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } mac_state_t;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // A dimension of 1 still gets a 1-bit index so ports never collapse to zero width.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mac_dot_unit.sv
// Dot-product datapath: registered signed/unsigned multiply feeding an
// accumulator that is wide enough to never overflow for the configured K.
module mac_dot_unit
    import mac_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic          signed_mode,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] acc,
    output logic          prod_valid
);

    logic [2*DW-1:0] a_ext;
    logic [2*DW-1:0] b_ext;
    logic [2*DW-1:0] prod_comb;
    logic [2*DW-1:0] prod_q;
    logic [RW-1:0]   prod_ext;

    // Extending both operands to 2*DW first makes the low 2*DW bits of a plain
    // multiply correct for two's-complement as well as unsigned operands.
    always_comb begin
        a_ext     = signed_mode ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
        b_ext     = signed_mode ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
        prod_comb = a_ext * b_ext;
        prod_ext  = signed_mode ? RW'($signed(prod_q)) : RW'(prod_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q     <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else if (clear) begin
            prod_q     <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
        end else begin
            prod_valid <= en;
            if (en) begin
                prod_q <= prod_comb;
            end
            if (prod_valid) begin
                acc <= acc + prod_ext;
            end
        end
    end

endmodule

// File: rtl/mac_matrix_engine.sv
// C = A * B engine: streams one dot product per result element from external
// operand memories and hands each element out through a valid/ready port.
module mac_matrix_engine
    import mac_pkg::*;
#(
    parameter int M                        = 2,
    parameter int K                        = 2,
    parameter int N                        = 2,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2*DATA_WIDTH_INIT_MATRIX + $clog2(K),
    parameter int RD_LATENCY               = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                stop,
    input  logic                                signed_mode,
    output logic [addr_width(M)-1:0]            row_addr_a,
    output logic [addr_width(K)-1:0]            col_addr_a,
    output logic [addr_width(K)-1:0]            row_addr_b,
    output logic [addr_width(N)-1:0]            col_addr_b,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [addr_width(M)-1:0]            res_row,
    output logic [addr_width(N)-1:0]            res_col,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] res_data,
    output logic                                busy,
    output logic                                mac_done,
    output logic                                aborted
);

    localparam int AWM = addr_width(M);
    localparam int AWK = addr_width(K);
    localparam int AWN = addr_width(N);
    localparam int RW  = DATA_WIDTH_RESULT_MATRIX;

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("mac_matrix_engine: RD_LATENCY out of range");
    end

    mac_state_t      state;
    mac_state_t      state_nxt;
    logic [AWM-1:0]  i_idx;
    logic [AWN-1:0]  j_idx;
    logic [AWK-1:0]  k_idx;
    logic [AWK-1:0]  acc_cnt;
    logic [RD_LATENCY-1:0] vpipe;
    logic            signed_q;
    logic            start_ok;
    logic            abort_now;
    logic            handshake;
    logic            last_k;
    logic            last_acc;
    logic            last_i;
    logic            last_j;
    logic            dot_clear;
    logic            prod_valid;
    logic [RW-1:0]   acc;

    // Abort has priority over every transition, including a same-cycle handshake.
    always_comb begin
        start_ok  = (state == ST_IDLE) && start && !stop;
        abort_now = (state != ST_IDLE) && stop;
        handshake = (state == ST_WRITE) && res_ready && !stop;
        last_k    = (k_idx == AWK'(K-1));
        last_acc  = (acc_cnt == AWK'(K-1));
        last_i    = (i_idx == AWM'(M-1));
        last_j    = (j_idx == AWN'(N-1));
        dot_clear = start_ok || abort_now || handshake;
        state_nxt = state;
        if (abort_now) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_ok) state_nxt = ST_FETCH;
                ST_FETCH: if (last_k) state_nxt = ST_DRAIN;
                ST_DRAIN: if (prod_valid && last_acc) state_nxt = ST_WRITE;
                ST_WRITE: if (res_ready) state_nxt = (last_i && last_j) ? ST_DONE : ST_FETCH;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            i_idx    <= '0;
            j_idx    <= '0;
            k_idx    <= '0;
            acc_cnt  <= '0;
            vpipe    <= '0;
            signed_q <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            aborted <= abort_now;
            if (start_ok || abort_now) begin
                i_idx   <= '0;
                j_idx   <= '0;
                k_idx   <= '0;
                acc_cnt <= '0;
                vpipe   <= '0;
                if (start_ok) begin
                    signed_q <= signed_mode;
                end
            end else begin
                // vpipe[RD_LATENCY-1] lines up with the read data of an earlier re.
                vpipe <= (vpipe << 1) | RD_LATENCY'(state == ST_FETCH);
                if (state == ST_FETCH) begin
                    k_idx <= last_k ? '0 : k_idx + AWK'(1);
                end
                if (prod_valid) begin
                    acc_cnt <= last_acc ? '0 : acc_cnt + AWK'(1);
                end
                if (handshake) begin
                    acc_cnt <= '0;
                    if (last_j) begin
                        j_idx <= '0;
                        i_idx <= last_i ? '0 : i_idx + AWM'(1);
                    end else begin
                        j_idx <= j_idx + AWN'(1);
                    end
                end
            end
        end
    end

    mac_dot_unit #(
        .DW (DATA_WIDTH_INIT_MATRIX),
        .RW (RW)
    ) u_dot (
        .clk         (clk),
        .reset       (reset),
        .clear       (dot_clear),
        .en          (vpipe[RD_LATENCY-1]),
        .signed_mode (signed_q),
        .a           (data_in_a),
        .b           (data_in_b),
        .acc         (acc),
        .prod_valid  (prod_valid)
    );

    always_comb begin
        matrix_a_re = (state == ST_FETCH);
        matrix_b_re = (state == ST_FETCH);
        row_addr_a  = i_idx;
        col_addr_a  = k_idx;
        row_addr_b  = k_idx;
        col_addr_b  = j_idx;
        res_valid   = (state == ST_WRITE);
        res_row     = i_idx;
        res_col     = j_idx;
        res_data    = acc;
        busy        = (state != ST_IDLE);
        mac_done    = (state == ST_DONE);
    end

endmodule

// File: tb/tb_mac_matrix_engine.sv
// Directed bench: a 2x2x2 engine with 1-cycle memory and a 2x3x2 engine with
// 3-cycle memory, each fed by a small behavioural operand memory.
module tb_mac_matrix_engine;

    localparam int DW = 8;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance 1: M=K=N=2, RD_LATENCY=1
    logic        start = 1'b0, stop = 1'b0, signed_mode = 1'b0, res_ready = 1'b1;
    logic [0:0]  row_addr_a, col_addr_a, row_addr_b, col_addr_b, res_row, res_col;
    logic        matrix_a_re, matrix_b_re, res_valid, busy, mac_done, aborted;
    logic [DW-1:0] data_in_a, data_in_b;
    logic [16:0] res_data;
    logic [DW-1:0] mem_a [2][2];
    logic [DW-1:0] mem_b [2][2];

    mac_matrix_engine #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(DW), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .signed_mode(signed_mode),
        .row_addr_a(row_addr_a), .col_addr_a(col_addr_a), .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
        .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re), .data_in_a(data_in_a), .data_in_b(data_in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_col(res_col), .res_data(res_data),
        .busy(busy), .mac_done(mac_done), .aborted(aborted));

    always @(posedge clk) begin
        data_in_a <= matrix_a_re ? mem_a[row_addr_a][col_addr_a] : 8'hA5;
        data_in_b <= matrix_b_re ? mem_b[row_addr_b][col_addr_b] : 8'h5A;
    end

    // Instance 2: M=2, K=3, N=2, RD_LATENCY=3
    logic        start_k3 = 1'b0, stop_k3 = 1'b0, signed_mode_k3 = 1'b0, res_ready_k3 = 1'b1;
    logic [0:0]  row_addr_a_k3, col_addr_b_k3, res_row_k3, res_col_k3;
    logic [1:0]  col_addr_a_k3, row_addr_b_k3;
    logic        matrix_a_re_k3, matrix_b_re_k3, res_valid_k3, busy_k3, mac_done_k3, aborted_k3;
    logic [DW-1:0] data_in_a_k3, data_in_b_k3;
    logic [17:0] res_data_k3;
    logic [DW-1:0] mem_a3 [2][3];
    logic [DW-1:0] mem_b3 [3][2];
    logic [DW-1:0] pipe_a3 [3];
    logic [DW-1:0] pipe_b3 [3];

    mac_matrix_engine #(.M(2), .K(3), .N(2), .DATA_WIDTH_INIT_MATRIX(DW), .RD_LATENCY(3)) dut_k3 (
        .clk(clk), .reset(reset), .start(start_k3), .stop(stop_k3), .signed_mode(signed_mode_k3),
        .row_addr_a(row_addr_a_k3), .col_addr_a(col_addr_a_k3), .row_addr_b(row_addr_b_k3), .col_addr_b(col_addr_b_k3),
        .matrix_a_re(matrix_a_re_k3), .matrix_b_re(matrix_b_re_k3), .data_in_a(data_in_a_k3), .data_in_b(data_in_b_k3),
        .res_valid(res_valid_k3), .res_ready(res_ready_k3), .res_row(res_row_k3), .res_col(res_col_k3), .res_data(res_data_k3),
        .busy(busy_k3), .mac_done(mac_done_k3), .aborted(aborted_k3));

    always @(posedge clk) begin
        pipe_a3[0] <= matrix_a_re_k3 ? mem_a3[row_addr_a_k3][col_addr_a_k3] : 8'hA5;
        pipe_b3[0] <= matrix_b_re_k3 ? mem_b3[row_addr_b_k3][col_addr_b_k3] : 8'h5A;
        pipe_a3[1] <= pipe_a3[0];
        pipe_b3[1] <= pipe_b3[0];
        pipe_a3[2] <= pipe_a3[1];
        pipe_b3[2] <= pipe_b3[1];
    end
    assign data_in_a_k3 = pipe_a3[2];
    assign data_in_b_k3 = pipe_b3[2];

    // Delivered elements and status pulses, sampled mid-cycle
    logic [16:0] q_data[$];
    logic        q_row[$];
    logic        q_col[$];
    logic [17:0] q3_data[$];
    logic        q3_row[$];
    logic        q3_col[$];
    int done_cnt = 0, abort_cnt = 0, re_cnt = 0, done3_cnt = 0;

    always @(negedge clk) begin
        if (!reset && res_valid && res_ready && !stop) begin
            q_data.push_back(res_data);
            q_row.push_back(res_row);
            q_col.push_back(res_col);
        end
        if (!reset && res_valid_k3 && res_ready_k3 && !stop_k3) begin
            q3_data.push_back(res_data_k3);
            q3_row.push_back(res_row_k3);
            q3_col.push_back(res_col_k3);
        end
        if (mac_done) done_cnt++;
        if (aborted) abort_cnt++;
        if (matrix_a_re) re_cnt++;
        if (mac_done_k3) done3_cnt++;
    end

    task automatic load_2x2(input int a0, a1, a2, a3, b0, b1, b2, b3);
        mem_a[0][0] = 8'(a0); mem_a[0][1] = 8'(a1); mem_a[1][0] = 8'(a2); mem_a[1][1] = 8'(a3);
        mem_b[0][0] = 8'(b0); mem_b[0][1] = 8'(b1); mem_b[1][0] = 8'(b2); mem_b[1][1] = 8'(b3);
    endtask

    // Start a run with mode sm, flip signed_mode afterwards, wait for mac_done
    task automatic run_2x2(input logic sm, output bit ok);
        int base_done;
        base_done = done_cnt;
        @(posedge clk); #1; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; signed_mode = ~sm;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (done_cnt != base_done);
        end
    endtask

    task automatic wait_done_k3(input int base_done, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (done3_cnt != base_done);
        end
    endtask

    task automatic test_reset;
        load_2x2(1, 2, 3, 4, 5, 6, 7, 8);
        repeat (2) @(negedge clk);
        n_compared++;
        if ({busy, matrix_a_re, matrix_b_re, res_valid, mac_done, aborted} !== 6'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_status: got %b expected 000000", {busy, matrix_a_re, matrix_b_re, res_valid, mac_done, aborted});
        end
        n_compared++;
        if ({res_data, res_row, res_col, row_addr_a, col_addr_a, col_addr_b} !== 22'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data_addr: got %0h expected 0", {res_data, res_row, res_col, row_addr_a, col_addr_a, col_addr_b});
        end
        n_compared++;
        if ({busy_k3, matrix_a_re_k3, res_valid_k3, res_data_k3} !== 21'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_k3: got %0h expected 0", {busy_k3, matrix_a_re_k3, res_valid_k3, res_data_k3});
        end
        @(posedge clk); #1; reset = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; stop = 1'b1;
        n_compared++;
        if ({busy, matrix_a_re} !== 2'b11) begin
            n_mismatched++;
            $display("[TB] FAIL first_start: got busy,re=%b expected 11", {busy, matrix_a_re});
        end
        @(posedge clk); #1; stop = 1'b0;
        n_compared++;
        if ({busy, aborted, matrix_a_re} !== 3'b010) begin
            n_mismatched++;
            $display("[TB] FAIL first_stop: got busy,aborted,re=%b expected 010", {busy, aborted, matrix_a_re});
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_unsigned;
        int exp_d[4] = '{19, 22, 43, 50};
        int base, re_base, done_base, n;
        bit ok;
        load_2x2(1, 2, 3, 4, 5, 6, 7, 8);
        base = q_data.size(); re_base = re_cnt; done_base = done_cnt;
        @(posedge clk); #1; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_compared++;
        if (n !== 4) begin
            n_mismatched++;
            $display("[TB] FAIL unsigned_latency: got %0d cycles expected 4", n);
        end
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (done_cnt != done_base);
        end
        repeat (3) @(posedge clk);
        n_compared++;
        if (!ok || q_data.size() !== base + 4) begin
            n_mismatched++;
            $display("[TB] FAIL unsigned_count: got %0d results expected 4 (done seen %0b)", q_data.size() - base, ok);
        end
        for (int e = 0; e < 4; e++) begin
            n_compared++;
            if (q_data.size() <= base + e || q_data[base+e] !== 17'(exp_d[e]) ||
                q_row[base+e] !== 1'(e / 2) || q_col[base+e] !== 1'(e % 2)) begin
                n_mismatched++;
                $display("[TB] FAIL unsigned_elem%0d: got %0d expected %0d",
                         e, (q_data.size() > base + e) ? q_data[base+e] : 17'h0, exp_d[e]);
            end
        end
        n_compared++;
        if (done_cnt - done_base !== 1 || re_cnt - re_base !== 8) begin
            n_mismatched++;
            $display("[TB] FAIL unsigned_pulses: got done=%0d re=%0d expected done=1 re=8",
                     done_cnt - done_base, re_cnt - re_base);
        end
    endtask

    task automatic test_signed;
        int exp_s[4] = '{9, 22, -13, -50};
        int exp_u[4] = '{1289, 63766, 1779, 2766};
        int base;
        bit ok;
        load_2x2(-1, 2, 3, -4, 5, -6, 7, 8);
        base = q_data.size();
        run_2x2(1'b1, ok);
        n_compared++;
        if (!ok || q_data.size() !== base + 4) begin
            n_mismatched++;
            $display("[TB] FAIL signed_count: got %0d results expected 4", q_data.size() - base);
        end
        for (int e = 0; e < 4; e++) begin
            n_compared++;
            if (q_data.size() <= base + e || q_data[base+e] !== 17'(exp_s[e])) begin
                n_mismatched++;
                $display("[TB] FAIL signed_elem%0d: got %0h expected %0h",
                         e, (q_data.size() > base + e) ? q_data[base+e] : 17'h0, 17'(exp_s[e]));
            end
        end
        base = q_data.size();
        run_2x2(1'b0, ok);
        for (int e = 0; e < 4; e++) begin
            n_compared++;
            if (q_data.size() <= base + e || q_data[base+e] !== 17'(exp_u[e])) begin
                n_mismatched++;
                $display("[TB] FAIL same_bits_unsigned_elem%0d: got %0d expected %0d",
                         e, (q_data.size() > base + e) ? q_data[base+e] : 17'h0, exp_u[e]);
            end
        end
        signed_mode = 1'b0;
    endtask

    task automatic test_idle_stop;
        @(posedge clk); #1; stop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_compared++;
        if ({busy, aborted} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL idle_stop: got busy,aborted=%b expected 00", {busy, aborted});
        end
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_compared++;
        if ({busy, aborted, matrix_a_re} !== 3'b000) begin
            n_mismatched++;
            $display("[TB] FAIL idle_start_stop: got busy,aborted,re=%b expected 000", {busy, aborted, matrix_a_re});
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_abort;
        int base, done_base, abort_base;
        bit found;
        load_2x2(1, 2, 3, 4, 5, 6, 7, 8);
        base = q_data.size(); done_base = done_cnt; abort_base = abort_cnt;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            found = matrix_a_re && row_addr_a == 1'b1 && col_addr_a == 1'b1 && col_addr_b == 1'b0;
        end
        n_compared++;
        if (!found) begin
            n_mismatched++;
            $display("[TB] FAIL abort_reach_fetch: got timeout expected element (1,0) k=1");
        end
        stop = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({busy, aborted, matrix_a_re, res_valid, mac_done} !== 5'b01000) begin
            n_mismatched++;
            $display("[TB] FAIL abort_next_cycle: got busy,aborted,re,valid,done=%b expected 01000",
                     {busy, aborted, matrix_a_re, res_valid, mac_done});
        end
        stop = 1'b0;
        @(negedge clk);
        n_compared++;
        if (aborted !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_pulse_width: got %b expected 0", aborted);
        end
        repeat (20) @(negedge clk);
        n_compared++;
        if (q_data.size() - base !== 2 || done_cnt !== done_base || abort_cnt - abort_base !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL abort_aftermath: got results=%0d done=%0d aborts=%0d expected 2 0 1",
                     q_data.size() - base, done_cnt - done_base, abort_cnt - abort_base);
        end
    endtask

    task automatic test_back_to_back;
        int exp_d[4] = '{19, 22, 43, 50};
        int base, done_base;
        bit ok, found;
        load_2x2(1, 2, 3, 4, 5, 6, 7, 8);
        base = q_data.size(); done_base = done_cnt;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            ok = (done_cnt != done_base);
        end
        repeat (3) @(posedge clk);
        #1;
        n_compared++;
        if (!ok || q_data.size() - base !== 4 || done_cnt - done_base !== 1 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL busy_start_ignored: got results=%0d done=%0d busy=%b expected 4 1 0",
                     q_data.size() - base, done_cnt - done_base, busy);
        end
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            found = !matrix_a_re;
        end
        @(negedge clk);
        n_compared++;
        if (!found || res_data !== 17'd5 || res_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL drain_partial_acc: got %0d expected 5", res_data);
        end
        #1; reset = 1'b1;
        #1;
        n_compared++;
        if ({busy, matrix_a_re, res_valid, mac_done, aborted, res_row, res_col, res_data} !== 24'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_drain: got %0h expected 0",
                     {busy, matrix_a_re, res_valid, mac_done, aborted, res_row, res_col, res_data});
        end
        @(posedge clk); #1; reset = 1'b0;
        base = q_data.size();
        run_2x2(1'b0, ok);
        for (int e = 0; e < 4; e++) begin
            n_compared++;
            if (q_data.size() <= base + e || q_data[base+e] !== 17'(exp_d[e])) begin
                n_mismatched++;
                $display("[TB] FAIL after_reset_elem%0d: got %0d expected %0d",
                         e, (q_data.size() > base + e) ? q_data[base+e] : 17'h0, exp_d[e]);
            end
        end
        signed_mode = 1'b0;
    endtask

    task automatic test_wide_k3;
        int base, done_base, n;
        bit ok;
        for (int r = 0; r < 2; r++) for (int c = 0; c < 3; c++) mem_a3[r][c] = 8'd255;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 2; c++) mem_b3[r][c] = 8'd255;
        base = q3_data.size(); done_base = done3_cnt;
        @(posedge clk); #1; signed_mode_k3 = 1'b0; res_ready_k3 = 1'b1; start_k3 = 1'b1;
        @(posedge clk); #1; start_k3 = 1'b0;
        n = 0;
        while (!res_valid_k3 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        n_compared++;
        if (n !== 7) begin
            n_mismatched++;
            $display("[TB] FAIL k3_latency: got %0d cycles expected 7", n);
        end
        wait_done_k3(done_base, ok);
        n_compared++;
        if (!ok || q3_data.size() - base !== 4) begin
            n_mismatched++;
            $display("[TB] FAIL k3_count: got %0d results expected 4", q3_data.size() - base);
        end
        for (int e = 0; e < 4; e++) begin
            n_compared++;
            if (q3_data.size() <= base + e || q3_data[base+e] !== 18'd195075 ||
                q3_row[base+e] !== 1'(e / 2) || q3_col[base+e] !== 1'(e % 2)) begin
                n_mismatched++;
                $display("[TB] FAIL k3_full_scale_elem%0d: got %0d expected 195075",
                         e, (q3_data.size() > base + e) ? q3_data[base+e] : 18'h0);
            end
        end
    endtask

    task automatic test_stall;
        int exp_d[4] = '{40, 46, 94, 109};
        int base, done_base;
        bit ok, found;
        mem_a3[0][0] = 8'd1; mem_a3[0][1] = 8'd2; mem_a3[0][2] = 8'd3;
        mem_a3[1][0] = 8'd4; mem_a3[1][1] = 8'd5; mem_a3[1][2] = 8'd6;
        mem_b3[0][0] = 8'd4; mem_b3[0][1] = 8'd5;
        mem_b3[1][0] = 8'd6; mem_b3[1][1] = 8'd7;
        mem_b3[2][0] = 8'd8; mem_b3[2][1] = 8'd9;
        base = q3_data.size(); done_base = done3_cnt;
        @(posedge clk); #1; res_ready_k3 = 1'b1; start_k3 = 1'b1;
        @(posedge clk); #1; start_k3 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            found = res_valid_k3;
        end
        @(posedge clk); #1; res_ready_k3 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            found = res_valid_k3;
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            n_compared++;
            if (!found || res_valid_k3 !== 1'b1 || res_data_k3 !== 18'd46 || res_row_k3 !== 1'b0 ||
                res_col_k3 !== 1'b1 || matrix_a_re_k3 !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL stall_hold_cycle%0d: got valid=%b data=%0d col=%b re=%b expected 1 46 1 0",
                         c, res_valid_k3, res_data_k3, res_col_k3, matrix_a_re_k3);
            end
        end
        @(posedge clk); #1; res_ready_k3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_compared++;
        if ({matrix_a_re_k3, res_valid_k3, row_addr_a_k3, col_addr_a_k3} !== 5'b10100) begin
            n_mismatched++;
            $display("[TB] FAIL stall_next_re: got re,valid,row,k=%b expected 10100",
                     {matrix_a_re_k3, res_valid_k3, row_addr_a_k3, col_addr_a_k3});
        end
        wait_done_k3(done_base, ok);
        for (int e = 0; e < 4; e++) begin
            n_compared++;
            if (!ok || q3_data.size() <= base + e || q3_data[base+e] !== 18'(exp_d[e])) begin
                n_mismatched++;
                $display("[TB] FAIL stall_elem%0d: got %0d expected %0d",
                         e, (q3_data.size() > base + e) ? q3_data[base+e] : 18'h0, exp_d[e]);
            end
        end
    endtask

    initial begin
        $display("[TB] starting mac_matrix_engine bench");
        test_reset;
        test_unsigned;
        test_signed;
        test_idle_stop;
        test_abort;
        test_back_to_back;
        test_wide_k3;
        test_stall;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mac_matrix_engine.md
MAC_MATRIX_ENGINE -- requirements
Module: mac_matrix_engine

Interface
REQ-001 SHALL have parameter M, default 2: rows of A and C.
REQ-002 SHALL have parameter K, default 2: columns of A and rows of B (dot-product length).
REQ-003 SHALL have parameter N, default 2: columns of B and C.
REQ-004 SHALL have parameter DATA_WIDTH_INIT_MATRIX, default 32: operand width.
REQ-005 SHALL have parameter DATA_WIDTH_RESULT_MATRIX, default 2*DATA_WIDTH_INIT_MATRIX+$clog2(K): accumulator and result width.
REQ-006 SHALL have parameter RD_LATENCY, default 1, legal 1..4: operand memory read latency in cycles.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port start, input, 1 bit: begin a full C=A*B run; sampled only in IDLE.
REQ-010 SHALL have port stop, input, 1 bit: abort the current run.
REQ-011 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands; latched at start.
REQ-012 SHALL have ports row_addr_a/col_addr_a, outputs, $clog2(M)/$clog2(K) bits: A read address.
REQ-013 SHALL have ports row_addr_b/col_addr_b, outputs, $clog2(K)/$clog2(N) bits: B read address.
REQ-014 SHALL have ports matrix_a_re and matrix_b_re, outputs, 1 bit each: read enables, always equal to each other.
REQ-015 SHALL have ports data_in_a and data_in_b, inputs, DATA_WIDTH_INIT_MATRIX bits: read data, valid RD_LATENCY cycles after re.
REQ-016 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_row (output, $clog2(M)), res_col (output, $clog2(N)) and res_data (output, DATA_WIDTH_RESULT_MATRIX): result handshake.
REQ-017 SHALL have ports busy, mac_done and aborted, outputs, 1 bit each: status; mac_done and aborted are one-cycle pulses.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, DRAIN, WRITE and DONE.
REQ-019 IDLE->FETCH SHALL occur on start=1 and stop=0; the engine SHALL clear element indices i=0, j=0 and the accumulator.
REQ-020 In FETCH, re SHALL assert for exactly K consecutive cycles with addresses A(i,k) and B(k,j), k=0..K-1; it SHALL then move to DRAIN.
REQ-021 The engine SHALL carry a valid shift register of depth RD_LATENCY alongside re; each returning operand pair SHALL be multiplied into a product register and added to the accumulator on the following cycle.
REQ-022 Multiplication SHALL be signed or unsigned per the latched signed_mode; the product SHALL be sign- or zero-extended to DATA_WIDTH_RESULT_MATRIX before accumulation, so the sum never overflows.
REQ-023 DRAIN SHALL exit to WRITE the cycle after the K-th product is accumulated; latency from first re to res_valid is K+RD_LATENCY+1 cycles.
REQ-024 In WRITE, res_valid=1 with res_row=i, res_col=j and res_data=accumulator; all three SHALL be held stable until res_ready=1, and re SHALL stay 0.
REQ-025 On handshake, the engine SHALL increment j; on j=N-1 it SHALL wrap j to 0 and increment i; it SHALL clear the accumulator and return to FETCH. After element (M-1,N-1) it SHALL go to DONE instead.
REQ-026 DONE SHALL pulse mac_done for one cycle, then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start SHALL be ignored when not in IDLE.
REQ-029 stop=1 in any non-IDLE state SHALL force IDLE on the next edge; aborted SHALL pulse for one cycle, mac_done SHALL stay 0, and the valid pipe and accumulator SHALL be cleared. In-flight read data SHALL be discarded.
REQ-030 stop in IDLE SHALL have no effect; stop and start together in IDLE SHALL be ignored.
REQ-031 If stop and res_ready arrive in the same WRITE cycle, stop SHALL win and the element SHALL count as not delivered.
REQ-032 Degenerate M, K or N = 1 SHALL work, using 1-bit address ports tied to 0.

Reset
REQ-033 On reset=1 all outputs and state SHALL go to 0/IDLE asynchronously: re, addresses, res_*, busy, mac_done, aborted, accumulator, valid pipe and indices.
REQ-034 Reset deassertion SHALL be synchronised; the first start SHALL be accepted on the first edge after deassertion.

Structure
REQ-035 A shared package mac_pkg SHALL hold the FSM state enum and the RD_LATENCY legality constants.
REQ-036 One sub-module, mac_dot_unit, SHALL contain the signed/unsigned multiply, product register and accumulator with clear/enable.

Verification
REQ-037 Scenario: M=K=N=2, DW=8, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], res_ready=1 -> results (0,0)=19, (0,1)=22, (1,0)=43, (1,1)=50 in that order, then one mac_done pulse.
REQ-038 Scenario: signed_mode=1, A=[[-1,2],[3,-4]], B=[[5,-6],[7,8]] -> results 9, 22, -13, -50; the same bits with signed_mode=0 -> unsigned products.
REQ-039 Scenario: RD_LATENCY=3, res_ready held low 5 cycles on element (0,1) -> res_valid and res_data stable across the stall; the next re asserts the cycle after the handshake.
REQ-040 Scenario: stop asserted in the 2nd FETCH cycle of element (1,0) -> next cycle IDLE, aborted=1, busy=0, no further res_valid, mac_done never asserted.
REQ-041 Scenario: start pulsed while busy -> ignored; reset asserted mid-DRAIN -> all outputs 0 immediately, and a fresh start gives the correct full result.
REQ-042 Scenario: K=3, DW=8, unsigned, all operands 255 -> every element 195075 with no truncation.
